// File: rtl/comp_serial_nbit.sv
// Serial unsigned magnitude comparator: walks two WIDTH-bit operands two bits
// per clock, MSB slice first, and stops at the first unequal slice.

module comp2_slice (
   input  logic [1:0] a_i,
   input  logic [1:0] b_i,
   output logic       gt_o,
   output logic       eq_o,
   output logic       lt_o
);
   assign gt_o = (a_i > b_i);
   assign eq_o = (a_i == b_i);
   assign lt_o = (a_i < b_i);
endmodule

module comp_serial_nbit #(
   parameter int WIDTH = 8   // even, >= 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic             done,
   output logic             gt,
   output logic             eq,
   output logic             lt,
   output logic             state_dbg_o
);
   localparam int NS = WIDTH / 2;
   localparam int CW = (NS > 1) ? $clog2(NS) : 1;

   typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] sa_q, sb_q;
   logic [CW-1:0]    cnt_q;
   logic             busy_q, done_q, gt_q, eq_q, lt_q;
   logic             s_gt, s_eq, s_lt;

   comp2_slice u_slice (
      .a_i  (sa_q[WIDTH-1 -: 2]),
      .b_i  (sb_q[WIDTH-1 -: 2]),
      .gt_o (s_gt),
      .eq_o (s_eq),
      .lt_o (s_lt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         sa_q    <= '0;
         sb_q    <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         gt_q    <= 1'b0;
         eq_q    <= 1'b0;
         lt_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (start) begin
                  sa_q    <= a;
                  sb_q    <= b;
                  cnt_q   <= CW'(NS - 1);
                  gt_q    <= 1'b0;
                  eq_q    <= 1'b0;
                  lt_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_RUN;
               end
            end
            S_RUN: begin
               // First unequal slice decides; a fully equal walk ends on the last slice.
               if (!s_eq) begin
                  gt_q    <= s_gt;
                  lt_q    <= s_lt;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else if (cnt_q == '0) begin
                  eq_q    <= 1'b1;
                  done_q  <= 1'b1;
                  busy_q  <= 1'b0;
                  state_q <= S_IDLE;
               end else begin
                  sa_q  <= sa_q << 2;
                  sb_q  <= sb_q << 2;
                  cnt_q <= cnt_q - 1'b1;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign busy        = busy_q;
   assign done        = done_q;
   assign gt          = gt_q;
   assign eq          = eq_q;
   assign lt          = lt_q;
   assign state_dbg_o = (state_q == S_RUN);
endmodule

// File: tb/tb_comp_serial_nbit.sv
// Bench for comp_serial_nbit at WIDTH=8 and WIDTH=2: directed steps plus a
// seeded random sweep, results checked through expected queues.

module tb_comp_serial_nbit;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start8 = 1'b0, start2 = 1'b0;
   logic [7:0] a8 = '0, b8 = '0;
   logic [1:0] a2 = '0, b2 = '0;
   logic       busy8, done8, gt8, eq8, lt8, dbg8;
   logic       busy2, done2, gt2, eq2, lt2, dbg2;

   int errors = 0;
   int checks = 0;

   // expected entry: {gt,eq,lt, latency[7:0]}
   logic [10:0] exp8_q[$];
   logic [10:0] exp2_q[$];

   comp_serial_nbit #(.WIDTH(8)) u8 (
      .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8),
      .busy(busy8), .done(done8), .gt(gt8), .eq(eq8), .lt(lt8),
      .state_dbg_o(dbg8)
   );

   comp_serial_nbit #(.WIDTH(2)) u2 (
      .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2),
      .busy(busy2), .done(done2), .gt(gt2), .eq(eq2), .lt(lt2),
      .state_dbg_o(dbg2)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [10:0] model(input logic [7:0] a, input logic [7:0] b, input int w);
      logic [2:0] res;
      int         k;
      int         ns;
      logic       found;
      ns    = w / 2;
      k     = ns;
      found = 1'b0;
      res   = (a > b) ? 3'b100 : (a == b) ? 3'b010 : 3'b001;
      for (int i = 0; i < ns; i++) begin
         if (!found && (a[w-1-2*i -: 2] != b[w-1-2*i -: 2])) begin
            k     = i + 1;
            found = 1'b1;
         end
      end
      return {res, 8'(k)};
   endfunction

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   // Drive one start pulse; returns at E0 + #1.
   task automatic start8_t(input logic [7:0] a, input logic [7:0] b);
      exp8_q.push_back(model(a, b, 8));
      a8 = a; b8 = b; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("w8_busy_after_start", busy8, 1'b1);
      check("w8_res_cleared", {gt8, eq8, lt8}, 3'b000);
   endtask

   // Count edges until done; pre = edges already elapsed since E0.
   task automatic wait8_t(input int pre);
      logic [10:0] e;
      int          lat;
      lat = pre;
      while (!done8 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
         if (!done8) check("w8_busy_running", {busy8, gt8, eq8, lt8}, 4'b1000);
      end
      e = exp8_q.pop_front();
      check("w8_done_seen", done8, 1'b1);
      check("w8_result", {gt8, eq8, lt8}, e[10:8]);
      check("w8_latency", lat, 32'(e[7:0]));
      check("w8_busy_at_done", busy8, 1'b0);
   endtask

   task automatic start2_t(input logic [1:0] a, input logic [1:0] b);
      exp2_q.push_back(model({6'b0, a}, {6'b0, b}, 2));
      a2 = a; b2 = b; start2 = 1'b1;
      @(posedge clk); #1;
      start2 = 1'b0;
      check("w2_busy_after_start", busy2, 1'b1);
   endtask

   task automatic wait2_t();
      logic [10:0] e;
      int          lat;
      lat = 0;
      while (!done2 && lat < 20) begin
         @(posedge clk); #1;
         lat++;
      end
      e = exp2_q.pop_front();
      check("w2_done_seen", done2, 1'b1);
      check("w2_result", {gt2, eq2, lt2}, e[10:8]);
      check("w2_latency", lat, 32'(e[7:0]));
   endtask

   initial begin
      logic [7:0] ra, rb;
      logic       saw_done;
      void'($urandom(32'd20240611));

      // reset state
      do_reset();
      check("rst_outputs8", {busy8, done8, gt8, eq8, lt8, dbg8}, 6'b0);
      check("rst_outputs2", {busy2, done2, gt2, eq2, lt2, dbg2}, 6'b0);

      // equal operands walk all four slices
      start8_t(8'hA5, 8'hA5);
      wait8_t(0);
      @(posedge clk); #1;
      check("t1_done_one_cycle", done8, 1'b0);
      check("t1_result_held", {gt8, eq8, lt8}, 3'b010);

      // top slice decides
      start8_t(8'hC0, 8'h80);
      wait8_t(0);

      // only the last slice differs
      start8_t(8'h34, 8'h36);
      wait8_t(0);

      // start while busy is ignored, then back-to-back start in the done cycle
      start8_t(8'h10, 8'h20);
      a8 = 8'hFF; b8 = 8'h00; start8 = 1'b1;
      @(posedge clk); #1;
      start8 = 1'b0;
      check("t4_still_busy", {busy8, done8}, 2'b10);
      wait8_t(1);
      start8_t(8'h00, 8'h00);
      check("t4_no_done_after_b2b", done8, 1'b0);
      wait8_t(0);

      // reset mid-compare wins over a simultaneous start
      start8_t(8'h5A, 8'h5A);
      @(posedge clk); #1;
      rst = 1'b1; start8 = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; start8 = 1'b0;
      void'(exp8_q.pop_front());
      check("t5_after_rst", {busy8, done8, gt8, eq8, lt8, dbg8}, 6'b0);
      saw_done = 1'b0;
      repeat (8) begin
         @(posedge clk); #1;
         saw_done = saw_done | done8 | busy8;
      end
      check("t5_no_activity", saw_done, 1'b0);

      // WIDTH=2 exhaustive corners
      for (int i = 0; i < 16; i++) begin
         start2_t(2'(i >> 2), 2'(i));
         wait2_t();
      end

      // seeded random sweep
      for (int i = 0; i < 200; i++) begin
         ra = 8'($urandom_range(0, 255));
         case ($urandom_range(0, 2))
            0:       rb = ra;
            1:       rb = ra ^ (8'h01 << $urandom_range(0, 7));
            default: rb = 8'($urandom_range(0, 255));
         endcase
         start8_t(ra, rb);
         wait8_t(0);
      end
      for (int i = 0; i < 60; i++) begin
         start2_t(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
         wait2_t();
      end

      check("queues_drained", exp8_q.size() + exp2_q.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
